udp_cmd_demux: RTL and testbench
================================

Name: udp_cmd_demux

Overview:
- Ingress counterpart of the UDP reply multiplexer.
- Accepts UDP command frames from the switch-side 8-bit LocalLink receive stream.
- Extracts a channel number from a fixed header byte and steers the whole frame onto the address-selected write bus of the per-channel command FIFOs (0..MaxUdpCh).
- Drops frames for invalid or full channels, and runt frames, counting each case.

Parameters:
- ChByteIdx, 6'd37: 0-based byte index of the channel byte (UDP dst-port low byte). Must be ≤ 62.
- ChMask, 6'h3F: mask applied to the channel byte.
- MaxUdpCh, 6'd20: highest valid channel.
- StatusLat, 8'd3: wait cycles after driving udp_rx_wr_addr before sampling status.
- GapCycles, 8'd4: wr_enable hold cycles after end of frame.

Ports:
- udp_sw_rx_clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high
- udp_sw_rx_sof_n  in  1  start of frame
- udp_sw_rx_data_in  in  8  frame byte
- udp_sw_rx_eof_n  in  1  end of frame
- udp_sw_rx_src_rdy_n  in  1  source byte valid
- udp_sw_rx_dst_rdy_n  out  1  demux ready; a byte transfers when src_rdy_n=0 and dst_rdy_n=0
- udp_rx_wr_addr  out  6  selected channel FIFO
- udp_rx_wr_enable  out  1  FIFO write enable
- udp_rx_wr_data  out  8  write byte
- udp_rx_wr_data_valid  out  1  byte strobe
- udp_rx_wr_good_frame  out  1  commit pulse
- udp_rx_wr_bad_frame  out  1  discard pulse
- udp_rx_wr_fifo_status  in  4  fill status of the addressed FIFO; 4'hf means full
- udp_rx_wr_overflow  in  1  overflow flag of the addressed FIFO
- udp_rx_frame_cnt  out  16  frames committed good (wrapping)
- udp_rx_drop_cnt  out  16  frames dropped, any reason (wrapping)

Behaviour:
- Reset (async): all outputs 0, except dst_rdy_n=1. State=IDLE. Reset mid-frame abandons the frame with no good/bad pulse. After reset, input bytes are discarded until the next sof_n=0 transfer.
- All outputs are registered.
- IDLE:
  - dst_rdy_n=0; wr_enable=0.
  - A transfer with sof_n=1 is discarded.
  - A transfer with sof_n=0 stores the byte in hdr[0] and goes to HDR with idx=1.
- HDR:
  - Each transfer stores hdr[idx] and increments idx.
  - Transfer at idx==ChByteIdx: latch ch=data&ChMask, latch eof_seen=!eof_n, set dst_rdy_n=1, go to SEL.
  - eof transfer before idx==ChByteIdx: runt frame; drop_cnt+1, go to IDLE. Nothing is written to any FIFO.
- SEL:
  - wr_addr<=ch; wait StatusLat cycles, then go to CHK.
- CHK:
  - If ch>MaxUdpCh or status==4'hf: drop_cnt+1. If eof_seen, go to IDLE; otherwise go to DROP.
  - Otherwise go to REPLAY, wr_enable=1.
- DROP:
  - dst_rdy_n=0; consume bytes until an eof transfer, then go to IDLE.
  - No FIFO activity.
- REPLAY:
  - Emit hdr[0..ChByteIdx], one byte per cycle, data_valid=1.
  - After the last byte: if eof_seen, go to END; otherwise go to STREAM.
- STREAM:
  - dst_rdy_n=0.
  - Each transfer appears on wr_data with data_valid=1 exactly one cycle later (1-cycle pipeline).
  - Bubbles in src_rdy_n give data_valid=0.
  - On an eof transfer: dst_rdy_n=1 next cycle, go to END.
- END:
  - Cycle 1, after the last data_valid: pulse good_frame, or bad_frame instead if wr_overflow was sampled high at any time since REPLAY entry.
  - good_frame increments frame_cnt.
  - Then hold wr_enable=1, data_valid=0 for GapCycles more cycles. Then wr_enable=0, go to IDLE.
- Invariants:
  - wr_addr is constant from SEL until IDLE.
  - good_frame and bad_frame are never both high.
  - data_valid is only high while wr_enable=1.
- A sof_n=0 seen mid-frame is treated as ordinary data. Framing is defined by eof only.

Decomposition:
- Shared package udp_pkg holds: state encodings (one-hot, 8 states), STATUS_FULL=4'hf, LocalLink active-low level constants, and a default MaxUdpCh shared with the reply mux.
- One natural sub-module: udp_hdr_buf, a 64x8 register array with write index, read index and clear. The FSM and counters stay in the top level.

Test Plan:
- ChByteIdx=3, 10-byte frame, byte3=8'h05, status=4'h0:
  - wr_addr=5; 10 data_valid bytes in order.
  - good_frame 1 cycle after the last byte; frame_cnt=1.
- Channel byte 8'h17 (23 > MaxUdpCh=20):
  - No wr_enable; all 10 bytes consumed; drop_cnt=1; next frame accepted normally.
- Channel 2 with status=4'hf:
  - Frame dropped, drop_cnt+1.
  - Repeat with status=4'h3: written, good_frame.
- Runt frame, eof on byte 2 with ChByteIdx=3:
  - No FIFO write, drop_cnt+1, back to IDLE with dst_rdy_n=0.
- Frame of exactly 4 bytes (eof on the channel byte), plus a frame with src_rdy_n bubbles every other cycle:
  - Byte order intact; data_valid gaps match the bubbles; good_frame once per frame.
- wr_overflow pulsed mid-STREAM:
  - bad_frame pulses instead of good_frame; frame_cnt unchanged.
- Reset asserted mid-STREAM:
  - Outputs return to reset values asynchronously.
  - Tail bytes ignored until the next sof.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP command demux and its reply-side counterpart.
package udp_pkg;

  typedef enum logic [7:0] {
    StIdle   = 8'b0000_0001,
    StHdr    = 8'b0000_0010,
    StSel    = 8'b0000_0100,
    StChk    = 8'b0000_1000,
    StDrop   = 8'b0001_0000,
    StReplay = 8'b0010_0000,
    StStream = 8'b0100_0000,
    StEnd    = 8'b1000_0000
  } dmx_state_e;

  localparam logic [3:0] STATUS_FULL = 4'hf;

  // LocalLink handshake and framing signals are active-low.
  localparam logic LL_ACTIVE = 1'b0;
  localparam logic LL_IDLE   = 1'b1;

  localparam logic [5:0] MAX_UDP_CH = 6'd20;

endpackage

// File: rtl/udp_cmd_demux_if.sv
// LocalLink receive stream plus the address-selected command FIFO write bus.
interface udp_cmd_demux_if;

  logic       udp_sw_rx_sof_n;
  logic [7:0] udp_sw_rx_data_in;
  logic       udp_sw_rx_eof_n;
  logic       udp_sw_rx_src_rdy_n;
  logic       udp_sw_rx_dst_rdy_n;

  logic [5:0] udp_rx_wr_addr;
  logic       udp_rx_wr_enable;
  logic [7:0] udp_rx_wr_data;
  logic       udp_rx_wr_data_valid;
  logic       udp_rx_wr_good_frame;
  logic       udp_rx_wr_bad_frame;
  logic [3:0] udp_rx_wr_fifo_status;
  logic       udp_rx_wr_overflow;

  // Environment side: frame source and FIFO bank.
  modport master (
    output udp_sw_rx_sof_n, udp_sw_rx_data_in, udp_sw_rx_eof_n, udp_sw_rx_src_rdy_n,
    output udp_rx_wr_fifo_status, udp_rx_wr_overflow,
    input  udp_sw_rx_dst_rdy_n,
    input  udp_rx_wr_addr, udp_rx_wr_enable, udp_rx_wr_data, udp_rx_wr_data_valid,
    input  udp_rx_wr_good_frame, udp_rx_wr_bad_frame
  );

  // Demux side.
  modport slave (
    input  udp_sw_rx_sof_n, udp_sw_rx_data_in, udp_sw_rx_eof_n, udp_sw_rx_src_rdy_n,
    input  udp_rx_wr_fifo_status, udp_rx_wr_overflow,
    output udp_sw_rx_dst_rdy_n,
    output udp_rx_wr_addr, udp_rx_wr_enable, udp_rx_wr_data, udp_rx_wr_data_valid,
    output udp_rx_wr_good_frame, udp_rx_wr_bad_frame
  );

endinterface

// File: rtl/udp_hdr_buf.sv
// 64x8 header holding buffer: indexed write, combinational indexed read, bulk clear.
module udp_hdr_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [5:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_idx,
  input  logic       clr,
  output logic [7:0] rd_data
);

  localparam int unsigned Depth = 64;

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= 8'h00;
    end else if (clr) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= 8'h00;
    end else if (we) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/udp_cmd_demux.sv
// Steers UDP command frames to the per-channel command FIFO chosen by a header byte.
module udp_cmd_demux
  import udp_pkg::*;
#(
  parameter logic [5:0] ChByteIdx = 6'd37,
  parameter logic [5:0] ChMask    = 6'h3F,
  parameter logic [5:0] MaxUdpCh  = MAX_UDP_CH,
  parameter logic [7:0] StatusLat = 8'd3,
  parameter logic [7:0] GapCycles = 8'd4
) (
  input  logic        udp_sw_rx_clk,
  input  logic        reset,
  udp_cmd_demux_if.slave bus,
  output logic [15:0] udp_rx_frame_cnt,
  output logic [15:0] udp_rx_drop_cnt
);

  dmx_state_e st_q, st_d;

  logic [5:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  ch_q, ch_d;
  logic        eof_seen_q, eof_seen_d;
  logic        ovf_q, ovf_d;

  logic        dst_rdy_n_q, dst_rdy_n_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_dv_q, wr_dv_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        hb_we;
  logic        hb_clr;
  logic [5:0]  hb_widx;
  logic [7:0]  hb_rdata;

  logic        xfer;
  logic        sof;
  logic        eof;
  logic        status_full;

  assign xfer        = (bus.udp_sw_rx_src_rdy_n == LL_ACTIVE) && (dst_rdy_n_q == LL_ACTIVE);
  assign sof         = bus.udp_sw_rx_sof_n == LL_ACTIVE;
  assign eof         = bus.udp_sw_rx_eof_n == LL_ACTIVE;
  assign status_full = bus.udp_rx_wr_fifo_status == STATUS_FULL;

  udp_hdr_buf u_hdr_buf (
    .clk     (udp_sw_rx_clk),
    .rst     (reset),
    .we      (hb_we),
    .wr_idx  (hb_widx),
    .wr_data (bus.udp_sw_rx_data_in),
    .rd_idx  (idx_q),
    .clr     (hb_clr),
    .rd_data (hb_rdata)
  );

  always_comb begin
    st_d        = st_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    eof_seen_d  = eof_seen_q;
    ovf_d       = ovf_q;
    dst_rdy_n_d = dst_rdy_n_q;
    wr_addr_d   = wr_addr_q;
    wr_en_d     = wr_en_q;
    wr_data_d   = wr_data_q;
    wr_dv_d     = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    hb_we       = 1'b0;
    hb_clr      = 1'b0;
    hb_widx     = idx_q;

    unique case (st_q)
      StIdle: begin
        dst_rdy_n_d = LL_ACTIVE;
        wr_en_d     = 1'b0;
        if (xfer && sof) begin
          // A one-byte frame can never reach the channel byte.
          if (eof) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            hb_we   = 1'b1;
            hb_widx = 6'd0;
            idx_d   = 6'd1;
            st_d    = StHdr;
          end
        end
      end

      StHdr: begin
        if (xfer) begin
          hb_we = 1'b1;
          idx_d = idx_q + 6'd1;
          if (idx_q == ChByteIdx) begin
            ch_d        = bus.udp_sw_rx_data_in[5:0] & ChMask;
            eof_seen_d  = eof;
            dst_rdy_n_d = LL_IDLE;
            cnt_d       = 8'd0;
            st_d        = StSel;
          end else if (eof) begin
            hb_we      = 1'b0;
            hb_clr     = 1'b1;
            drop_cnt_d = drop_cnt_q + 16'd1;
            st_d       = StIdle;
          end
        end
      end

      StSel: begin
        // Give the FIFO bank time to present status for the new address.
        wr_addr_d = ch_q;
        if (cnt_q == StatusLat) begin
          cnt_d = 8'd0;
          st_d  = StChk;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StChk: begin
        if ((ch_q > MaxUdpCh) || status_full) begin
          drop_cnt_d  = drop_cnt_q + 16'd1;
          dst_rdy_n_d = LL_ACTIVE;
          st_d        = eof_seen_q ? StIdle : StDrop;
        end else begin
          wr_en_d = 1'b1;
          idx_d   = 6'd0;
          ovf_d   = 1'b0;
          st_d    = StReplay;
        end
      end

      StDrop: begin
        dst_rdy_n_d = LL_ACTIVE;
        if (xfer && eof) st_d = StIdle;
      end

      StReplay: begin
        ovf_d     = ovf_q | bus.udp_rx_wr_overflow;
        wr_data_d = hb_rdata;
        wr_dv_d   = 1'b1;
        idx_d     = idx_q + 6'd1;
        if (idx_q == ChByteIdx) begin
          if (eof_seen_q) begin
            cnt_d = 8'd0;
            st_d  = StEnd;
          end else begin
            dst_rdy_n_d = LL_ACTIVE;
            st_d        = StStream;
          end
        end
      end

      StStream: begin
        ovf_d = ovf_q | bus.udp_rx_wr_overflow;
        if (xfer) begin
          wr_data_d = bus.udp_sw_rx_data_in;
          wr_dv_d   = 1'b1;
          if (eof) begin
            dst_rdy_n_d = LL_IDLE;
            cnt_d       = 8'd0;
            st_d        = StEnd;
          end
        end
      end

      StEnd: begin
        if (cnt_q == 8'd0) begin
          if (ovf_q || bus.udp_rx_wr_overflow) begin
            bad_d = 1'b1;
          end else begin
            good_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
        if (cnt_q == GapCycles) begin
          st_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge udp_sw_rx_clk or posedge reset) begin
    if (reset) begin
      st_q        <= StIdle;
      idx_q       <= 6'd0;
      cnt_q       <= 8'd0;
      ch_q        <= 6'd0;
      eof_seen_q  <= 1'b0;
      ovf_q       <= 1'b0;
      dst_rdy_n_q <= LL_IDLE;
      wr_addr_q   <= 6'd0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 8'h00;
      wr_dv_q     <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      eof_seen_q  <= eof_seen_d;
      ovf_q       <= ovf_d;
      dst_rdy_n_q <= dst_rdy_n_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      wr_dv_q     <= wr_dv_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.udp_sw_rx_dst_rdy_n  = dst_rdy_n_q;
  assign bus.udp_rx_wr_addr       = wr_addr_q;
  assign bus.udp_rx_wr_enable     = wr_en_q;
  assign bus.udp_rx_wr_data       = wr_data_q;
  assign bus.udp_rx_wr_data_valid = wr_dv_q;
  assign bus.udp_rx_wr_good_frame = good_q;
  assign bus.udp_rx_wr_bad_frame  = bad_q;
  assign udp_rx_frame_cnt         = frame_cnt_q;
  assign udp_rx_drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_udp_cmd_demux.sv
// Bench for udp_cmd_demux: directed vector table, random frames vs. a frame-level model, reset.
module tb_udp_cmd_demux;

  localparam int CH_IDX = 3;
  localparam int MAX_CH = 20;

  typedef struct {
    bit         wr;
    logic [5:0] addr;
    bit         bad;
  } res_t;

  typedef struct {
    logic [7:0] ch_byte;
    int         len;
    logic [3:0] status;
    bit         bubbles;
    bit         ovf;
    res_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  udp_cmd_demux_if bus ();

  always #5 clk = ~clk;

  udp_cmd_demux #(
    .ChByteIdx (6'd3)
  ) dut (
    .udp_sw_rx_clk    (clk),
    .reset            (reset),
    .bus              (bus),
    .udp_rx_frame_cnt (frame_cnt),
    .udp_rx_drop_cnt  (drop_cnt)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] cap[$];
  int         cap_t[$];
  int         n_good, n_bad, t_pulse;
  int         cyc = 0;
  bit         en_seen;
  int         exp_frame = 0;
  int         exp_drop = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // Frame-level reference: what the FIFO bank should see for a whole frame.
  function automatic res_t model(input logic [7:0] b[$], input logic [3:0] status, input bit ovf);
    res_t r;
    int   ch;
    r.wr   = 1'b0;
    r.addr = 6'd0;
    r.bad  = 1'b0;
    if (b.size() > CH_IDX) begin
      ch = int'(b[CH_IDX]) % 64;
      if (ch <= MAX_CH && status != 4'hf) begin
        r.wr   = 1'b1;
        r.addr = 6'(ch);
        r.bad  = ovf;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.udp_rx_wr_data_valid) begin
        cap.push_back(bus.udp_rx_wr_data);
        cap_t.push_back(cyc);
      end
      if (bus.udp_rx_wr_good_frame || bus.udp_rx_wr_bad_frame) t_pulse = cyc;
      if (bus.udp_rx_wr_good_frame) n_good++;
      if (bus.udp_rx_wr_bad_frame) n_bad++;
      if (bus.udp_rx_wr_enable) en_seen = 1'b1;
      check("good_bad_exclusive", int'(bus.udp_rx_wr_good_frame & bus.udp_rx_wr_bad_frame), 0);
      check("valid_needs_enable", int'(bus.udp_rx_wr_data_valid & ~bus.udp_rx_wr_enable), 0);
    end
    cyc++;
  end

  task automatic idle_inputs();
    bus.udp_sw_rx_src_rdy_n = 1'b1;
    bus.udp_sw_rx_sof_n     = 1'b1;
    bus.udp_sw_rx_eof_n     = 1'b1;
    bus.udp_rx_wr_overflow  = 1'b0;
  endtask

  task automatic drive_bytes(input logic [7:0] b[$], input bit sof_first, input bit eof_last,
                             input bit bubbles, input int ovf_at);
    int   i;
    int   guard;
    bit   idle_slot;
    logic rdy;
    i = 0;
    guard = 0;
    idle_slot = 1'b0;
    while (i < b.size()) begin
      @(negedge clk);
      bus.udp_rx_wr_overflow = (i == ovf_at);
      if (bubbles && idle_slot) begin
        bus.udp_sw_rx_src_rdy_n = 1'b1;
      end else begin
        bus.udp_sw_rx_src_rdy_n = 1'b0;
        bus.udp_sw_rx_data_in   = b[i];
        bus.udp_sw_rx_sof_n     = !(sof_first && i == 0);
        bus.udp_sw_rx_eof_n     = !(eof_last && i == b.size() - 1);
      end
      idle_slot = bubbles && !idle_slot;
      rdy = bus.udp_sw_rx_dst_rdy_n;
      @(posedge clk);
      if (!bus.udp_sw_rx_src_rdy_n && !rdy) i++;
      guard++;
      if (guard > 500) begin
        check("drive_timeout", i, int'(b.size()));
        break;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic clear_capture();
    @(posedge clk);
    cap.delete();
    cap_t.delete();
    n_good  = 0;
    n_bad   = 0;
    en_seen = 1'b0;
    t_pulse = -100;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b[$], input logic [3:0] status,
                           input bit bubbles, input bit ovf, input res_t exp);
    int mism;
    int gaps_bad;
    clear_capture();
    bus.udp_rx_wr_fifo_status = status;
    drive_bytes(b, 1'b1, 1'b1, bubbles, ovf ? int'(b.size()) - 2 : -1);
    repeat (40) @(negedge clk);
    if (exp.wr && !exp.bad) exp_frame++;
    if (!exp.wr) exp_drop++;
    check({tag, ":n_bytes"}, int'(cap.size()), exp.wr ? int'(b.size()) : 0);
    if (exp.wr && cap.size() == b.size()) begin
      mism = 0;
      for (int i = 0; i < b.size(); i++) if (cap[i] !== b[i]) mism++;
      check({tag, ":byte_order"}, mism, 0);
      check({tag, ":pulse_latency"}, t_pulse - cap_t[cap_t.size() - 1], 1);
      if (bubbles && b.size() > CH_IDX + 2) begin
        gaps_bad = 0;
        for (int i = CH_IDX + 2; i < b.size(); i++) if (cap_t[i] - cap_t[i - 1] != 2) gaps_bad++;
        check({tag, ":bubble_gaps"}, gaps_bad, 0);
      end
    end
    if (exp.wr) check({tag, ":wr_addr"}, int'(bus.udp_rx_wr_addr), int'(exp.addr));
    check({tag, ":good_pulses"}, n_good, int'(exp.wr && !exp.bad));
    check({tag, ":bad_pulses"}, n_bad, int'(exp.wr && exp.bad));
    check({tag, ":wr_enable_seen"}, int'(en_seen), int'(exp.wr));
    check({tag, ":frame_cnt"}, int'(frame_cnt), exp_frame);
    check({tag, ":drop_cnt"}, int'(drop_cnt), exp_drop);
    check({tag, ":dst_rdy_idle"}, int'(bus.udp_sw_rx_dst_rdy_n), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":dst_rdy_n"}, int'(bus.udp_sw_rx_dst_rdy_n), 1);
    check({tag, ":wr_enable"}, int'(bus.udp_rx_wr_enable), 0);
    check({tag, ":wr_data_valid"}, int'(bus.udp_rx_wr_data_valid), 0);
    check({tag, ":wr_addr"}, int'(bus.udp_rx_wr_addr), 0);
    check({tag, ":good"}, int'(bus.udp_rx_wr_good_frame), 0);
    check({tag, ":bad"}, int'(bus.udp_rx_wr_bad_frame), 0);
    check({tag, ":frame_cnt"}, int'(frame_cnt), 0);
    check({tag, ":drop_cnt"}, int'(drop_cnt), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[11];
    logic [7:0] b[$];
    logic [7:0] v;
    res_t       r;
    logic [3:0] st;
    bit         bub, ovf;
    int         len;

    // ch_byte, len, status, bubbles, ovf, {wr, addr, bad}
    vecs[0]  = '{8'h05, 10, 4'h0, 1'b0, 1'b0, '{1'b1, 6'd5,  1'b0}};
    vecs[1]  = '{8'h17, 10, 4'h0, 1'b0, 1'b0, '{1'b0, 6'd0,  1'b0}};
    vecs[2]  = '{8'h02, 10, 4'hf, 1'b0, 1'b0, '{1'b0, 6'd0,  1'b0}};
    vecs[3]  = '{8'h02, 10, 4'h3, 1'b0, 1'b0, '{1'b1, 6'd2,  1'b0}};
    vecs[4]  = '{8'h05,  3, 4'h0, 1'b0, 1'b0, '{1'b0, 6'd0,  1'b0}};
    vecs[5]  = '{8'h14,  4, 4'h0, 1'b0, 1'b0, '{1'b1, 6'd20, 1'b0}};
    vecs[6]  = '{8'h15,  4, 4'h0, 1'b0, 1'b0, '{1'b0, 6'd0,  1'b0}};
    vecs[7]  = '{8'h09, 12, 4'h1, 1'b1, 1'b0, '{1'b1, 6'd9,  1'b0}};
    vecs[8]  = '{8'h47,  8, 4'he, 1'b0, 1'b0, '{1'b1, 6'd7,  1'b0}};
    vecs[9]  = '{8'h0b,  9, 4'h0, 1'b0, 1'b1, '{1'b1, 6'd11, 1'b1}};
    vecs[10] = '{8'h05,  1, 4'h0, 1'b0, 1'b0, '{1'b0, 6'd0,  1'b0}};

    reset = 1'b1;
    bus.udp_sw_rx_data_in     = 8'h00;
    bus.udp_rx_wr_fifo_status = 4'h0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 11; k++) begin
      b.delete();
      for (int i = 0; i < vecs[k].len; i++) begin
        v = 8'((64 + 13 * i + 3 * k) % 256);
        b.push_back(v);
      end
      if (vecs[k].len > CH_IDX) b[CH_IDX] = vecs[k].ch_byte;
      run_frame($sformatf("vec%0d", k), b, vecs[k].status, vecs[k].bubbles, vecs[k].ovf,
                vecs[k].exp);
    end

    for (int k = 0; k < 30; k++) begin
      len = $urandom_range(1, 14);
      b.delete();
      for (int i = 0; i < len; i++) begin
        v = 8'($urandom_range(0, 255));
        b.push_back(v);
      end
      if (len > CH_IDX && $urandom_range(0, 3) != 0) begin
        v = 8'($urandom_range(0, MAX_CH) + 64 * $urandom_range(0, 3));
        b[CH_IDX] = v;
      end
      st  = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom_range(0, 14));
      bub = 1'($urandom_range(0, 1));
      ovf = (len >= CH_IDX + 3) && ($urandom_range(0, 4) == 0);
      r   = model(b, st, ovf);
      run_frame($sformatf("rnd%0d", k), b, st, bub, ovf, r);
    end

    // Reset in the middle of the streaming phase.
    clear_capture();
    bus.udp_rx_wr_fifo_status = 4'h0;
    b.delete();
    for (int i = 0; i < 12; i++) begin
      v = 8'(8'hc0 + i);
      b.push_back(v);
    end
    b[CH_IDX] = 8'h05;
    drive_bytes(b[0:6], 1'b1, 1'b0, 1'b0, -1);
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_frame = 0;
    exp_drop = 0;
    clear_capture();
    drive_bytes(b[7:11], 1'b0, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("tail:n_bytes", int'(cap.size()), 0);
    check("tail:wr_enable_seen", int'(en_seen), 0);
    check("tail:drop_cnt", int'(drop_cnt), 0);
    check("tail:good_pulses", n_good, 0);
    b.delete();
    for (int i = 0; i < 6; i++) begin
      v = 8'(8'h10 + i);
      b.push_back(v);
    end
    b[CH_IDX] = 8'h06;
    r = '{1'b1, 6'd6, 1'b0};
    run_frame("after_reset", b, 4'h2, 1'b0, 1'b0, r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
